// File: rtl/mm3_pkg.sv
// mm3_pkg: shared constants and types for the 3x3 systolic matrix-multiply core.
//   DATA_W_DEF / ACC_W_DEF : default operand and accumulator widths
//   *_BASE / THR_ADDR      : register-file address map seen on wr_addr
//   RUN_LAST               : last value of the RUN skew counter
//   THR_RESET              : threshold value after reset
//   mm3_state_e            : control FSM states
package mm3_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int ACC_W_DEF  = 32;

    localparam int A_BASE    = 0;
    localparam int B_BASE    = 9;
    localparam int BIAS_BASE = 18;
    localparam int THR_ADDR  = 27;

    // Skewed 3x3 schedule: feed k reaches PE(i,j) at cnt = i+j+k, so the
    // last product (2,2,k=2) lands at cnt = 6.
    localparam int RUN_LAST  = 6;
    localparam int THR_RESET = -70;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } mm3_state_e;
endpackage

// File: rtl/mm3_pe.sv
// mm3_pe: one output-stationary processing element.
//   load  : preload acc with sign-extended bias and clear the a/b pass registers
//   en    : acc += a_in*b_in, pass a_in right and b_in down through one register
//   a_out / b_out : registered copies of a_in / b_in for the neighbouring PEs
//   acc   : running accumulator (wraps modulo 2^ACC_W)
module mm3_pe #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     load,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] bias,
    input  logic signed [DATA_W-1:0] a_in,
    input  logic signed [DATA_W-1:0] b_in,
    output logic signed [DATA_W-1:0] a_out,
    output logic signed [DATA_W-1:0] b_out,
    output logic signed [ACC_W-1:0]  acc
);
    logic signed [2*DATA_W-1:0] prod;

    // Widen before multiplying so the full signed product is kept.
    assign prod = (2*DATA_W)'(a_in) * (2*DATA_W)'(b_in);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc   <= '0;
            a_out <= '0;
            b_out <= '0;
        end else if (load) begin
            acc   <= ACC_W'(bias);
            a_out <= '0;
            b_out <= '0;
        end else if (en) begin
            acc   <= acc + ACC_W'(prod);
            a_out <= a_in;
            b_out <= b_in;
        end
    end
endmodule

// File: rtl/systolic_mm3_core.sv
// systolic_mm3_core: computes C = A*B + bias on a 3x3 systolic array and
// returns the thresholded 9-bit map result[3i+j] = (C[i][j] >= threshold).
//   clk, resetn             : clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data   : register-file writes (A 0-8, B 9-17, bias 18-26,
//                             threshold 27, 28-31 ignored); accepted only in IDLE
//   start                   : run request; busy/done/result report the run
//   acc_sel/acc_rdata       : debug accumulator read, present only when the
//                             MM_ACC_DEBUG_EN macro is defined (else reads 0)
//
// Handshake: start is sampled on a rising edge only while busy is low; that
// edge raises busy, which stays high for exactly 8 cycles. The cycle busy
// falls, done is high for one cycle and result holds the new map until the
// next run. While busy is high, start and wr_en are ignored (not queued).
// A start coinciding with a write in IDLE wins and the write is dropped.
//
// The control FSM state is held in 'state' (mm3_state_e) for observation.
module systolic_mm3_core
    import mm3_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wr_en,
    input  logic [4:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [8:0]        result,
    input  logic [3:0]        acc_sel,
    output logic [ACC_W-1:0]  acc_rdata
);
    mm3_state_e state;
    logic [2:0] cnt;

    logic signed [DATA_W-1:0] a_mat [9];
    logic signed [DATA_W-1:0] b_mat [9];
    logic signed [DATA_W-1:0] bias  [9];
    logic signed [DATA_W-1:0] thr;

    logic signed [DATA_W-1:0] a_feed [3];
    logic signed [DATA_W-1:0] b_feed [3];
    logic signed [DATA_W-1:0] a_pe_in  [3][3];
    logic signed [DATA_W-1:0] b_pe_in  [3][3];
    logic signed [DATA_W-1:0] a_pe_out [3][3];
    logic signed [DATA_W-1:0] b_pe_out [3][3];
    logic signed [DATA_W-1:0] a_unused [3];
    logic signed [DATA_W-1:0] b_unused [3];
    logic signed [ACC_W-1:0]  acc_q    [9];

    logic pe_load;
    logic pe_en;

    assign pe_load = (state == IDLE) && start;
    assign pe_en   = (state == RUN);

    // Skewed edge feeds: row r sees A[r][k] and column c sees B[k][c] when
    // cnt == r+k (resp. c+k); every other slot feeds zero.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            a_feed[r] = '0;
            b_feed[r] = '0;
            if (state == RUN) begin
                for (int k = 0; k < 3; k++) begin
                    if (int'(cnt) == r + k) begin
                        a_feed[r] = a_mat[r*3+k];
                        b_feed[r] = b_mat[k*3+r];
                    end
                end
            end
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_row
        for (genvar j = 0; j < 3; j++) begin : g_col
            if (j == 0) begin : g_a_edge
                assign a_pe_in[i][j] = a_feed[i];
            end else begin : g_a_link
                assign a_pe_in[i][j] = a_pe_out[i][j-1];
            end
            if (i == 0) begin : g_b_edge
                assign b_pe_in[i][j] = b_feed[j];
            end else begin : g_b_link
                assign b_pe_in[i][j] = b_pe_out[i-1][j];
            end

            mm3_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
                .clk    (clk),
                .resetn (resetn),
                .load   (pe_load),
                .en     (pe_en),
                .bias   (bias[i*3+j]),
                .a_in   (a_pe_in[i][j]),
                .b_in   (b_pe_in[i][j]),
                .a_out  (a_pe_out[i][j]),
                .b_out  (b_pe_out[i][j]),
                .acc    (acc_q[i*3+j])
            );
        end
        // Values leaving the right column / bottom row have no consumer.
        assign a_unused[i] = a_pe_out[i][2];
        assign b_unused[i] = b_pe_out[2][i];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            thr    <= DATA_W'(THR_RESET);
            for (int k = 0; k < 9; k++) begin
                a_mat[k] <= '0;
                b_mat[k] <= '0;
                bias[k]  <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end else if (wr_en) begin
                        for (int k = 0; k < 9; k++) begin
                            if (wr_addr == 5'(A_BASE + k))    a_mat[k] <= wr_data;
                            if (wr_addr == 5'(B_BASE + k))    b_mat[k] <= wr_data;
                            if (wr_addr == 5'(BIAS_BASE + k)) bias[k]  <= wr_data;
                        end
                        if (wr_addr == 5'(THR_ADDR)) thr <= wr_data;
                    end
                end
                RUN: begin
                    if (cnt == 3'(RUN_LAST)) state <= FIN;
                    else                     cnt   <= cnt + 3'd1;
                end
                FIN: begin
                    for (int k = 0; k < 9; k++)
                        result[k] <= (acc_q[k] >= ACC_W'(thr));
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MM_ACC_DEBUG_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_rdata <= '0;
        end else begin
            acc_rdata <= '0;
            for (int k = 0; k < 9; k++)
                if (acc_sel == 4'(k)) acc_rdata <= acc_q[k];
        end
    end
`else
    logic [3:0] acc_sel_unused;
    assign acc_sel_unused = acc_sel;
    assign acc_rdata      = '0;
`endif
endmodule

// File: tb/tb_systolic_mm3_core.sv
module tb_systolic_mm3_core;
    logic        clk = 1'b0;
    logic        resetn;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        start;
    logic        busy;
    logic        done;
    logic [8:0]  result;
    logic [3:0]  acc_sel;
    logic [31:0] acc_rdata;

    // Reference register file and expected-result scoreboard.
    int m_a [9];
    int m_b [9];
    int m_bias [9];
    int m_thr;
    logic [8:0] exp_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    systolic_mm3_core u_dut (
        .clk       (clk),
        .resetn    (resetn),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .acc_sel   (acc_sel),
        .acc_rdata (acc_rdata)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int k = 0; k < 9; k++) begin
            m_a[k] = 0; m_b[k] = 0; m_bias[k] = 0;
        end
        m_thr = -70;
    endfunction

    // Plain matrix product with 32-bit wrapping sums.
    function automatic logic [8:0] model_result();
        logic [8:0] r;
        int c;
        r = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                c = m_bias[i*3+j];
                for (int k = 0; k < 3; k++) c = c + m_a[i*3+k] * m_b[k*3+j];
                r[i*3+j] = (c >= m_thr);
            end
        return r;
    endfunction

    task automatic write_reg(input logic [4:0] addr, input logic [15:0] data);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = addr; wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
        if (addr < 5'd9)       m_a[addr]         = int'($signed(data));
        else if (addr < 5'd18) m_b[addr-5'd9]    = int'($signed(data));
        else if (addr < 5'd27) m_bias[addr-5'd18] = int'($signed(data));
        else if (addr == 5'd27) m_thr            = int'($signed(data));
    endtask

    task automatic load_all(input int a [9], input int b [9], input int bs [9], input int thr);
        for (int k = 0; k < 9; k++) write_reg(5'(k), 16'(a[k]));
        for (int k = 0; k < 9; k++) write_reg(5'(9 + k), 16'(b[k]));
        for (int k = 0; k < 9; k++) write_reg(5'(18 + k), 16'(bs[k]));
        write_reg(5'd27, 16'(thr));
    endtask

    // Pulse start, then watch 24 cycles; c=0 is the cycle after the start edge.
    // inject_at >= 0 drives a write of 50 to A[0][0] plus a second start in that cycle.
    task automatic run_once(input int inject_at, output int lat, output int busy_cyc,
                            output int dones, output logic [8:0] res);
        lat = -1; busy_cyc = 0; dones = 0; res = '0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 24; c++) begin
            if (busy) busy_cyc++;
            if (done) begin
                dones++;
                if (lat < 0) begin lat = c; res = result; end
            end
            if (c == inject_at) begin
                start = 1'b1; wr_en = 1'b1; wr_addr = 5'd0; wr_data = 16'd50;
            end else begin
                start = 1'b0; wr_en = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0; wr_en = 1'b0;
    endtask

    // Common run-and-score sequence used by most scenarios.
    task automatic test_run(input string name, input int inject_at);
        int lat, bc, dn;
        logic [8:0] res, expv;
        exp_q.push_back(model_result());
        run_once(inject_at, lat, bc, dn, res);
        expv = exp_q.pop_front();
        n_checks++;
        if (lat !== 8) begin
            n_fail++; $display("FAIL %s latency: got %0d expected 8", name, lat);
        end
        n_checks++;
        if (bc !== 8) begin
            n_fail++; $display("FAIL %s busy_cycles: got %0d expected 8", name, bc);
        end
        n_checks++;
        if (dn !== 1) begin
            n_fail++; $display("FAIL %s done_count: got %0d expected 1", name, dn);
        end
        n_checks++;
        if (res !== expv) begin
            n_fail++; $display("FAIL %s result: got %b expected %b", name, res, expv);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; acc_sel = '0;
        model_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, result} !== 11'd0) begin
            n_fail++; $display("FAIL reset_outputs: got busy=%b done=%b result=%b expected 0", busy, done, result);
        end
        n_checks++;
        if (acc_rdata !== 32'd0) begin
            n_fail++; $display("FAIL reset_acc_rdata: got %h expected 0", acc_rdata);
        end
        resetn = 1'b1;
        @(negedge clk);
        // All-zero registers against threshold -70 must set every bit.
        test_run("reset_zero_run", -1);
    endtask

    task automatic test_identity();
        int a [9] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        int b [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        int z [9] = '{default: 0};
        load_all(a, b, z, 5);
        // Addresses 28-31 must not disturb anything.
        write_reg(5'd28, 16'h1234);
        write_reg(5'd31, 16'h8000);
        n_checks++;
        if (model_result() !== 9'b111110000) begin
            n_fail++; $display("FAIL identity_model: got %b expected 111110000", model_result());
        end
        test_run("identity", -1);
    endtask

    task automatic test_bias_sign();
        int a [9] = '{default: -2};
        int b [9] = '{default: 3};
        int bs [9] = '{0, 0, 0, 0, 20, 0, 0, 0, 0};
        load_all(a, b, bs, -17);
        test_run("bias_sign", -1);
    endtask

    task automatic test_threshold();
        int a [9] = '{default: 100};
        int z [9] = '{default: 0};
        load_all(a, a, z, 32767);
        test_run("thr_max", -1);
        write_reg(5'd27, 16'd30000);
        test_run("thr_equal", -1);
    endtask

    task automatic test_busy_block();
        int a [9] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        int b [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        int z [9] = '{default: 0};
        load_all(a, b, z, 5);
        test_run("busy_inject", 3);
        // A[0][0] still 1: a second run must give the same identity map.
        test_run("busy_after", -1);
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({busy, done, result} !== 11'd0) begin
            n_fail++; $display("FAIL midrun_reset: got busy=%b done=%b result=%b expected 0", busy, done, result);
        end
        @(negedge clk);
        resetn = 1'b1;
        for (int c = 0; c < 10; c++) begin
            n_checks++;
            if (done !== 1'b0) begin
                n_fail++; $display("FAIL midrun_no_done: got %b expected 0 at cycle %0d", done, c);
            end
            @(negedge clk);
        end
        test_run("after_reset", -1);
    endtask

    task automatic test_wrap();
        int a [9] = '{default: -32768};
        int bs [9] = '{-32768, 0, 0, 0, 0, 0, 0, 0, 0};
        load_all(a, a, bs, 0);
        test_run("wrap", -1);
        acc_sel = 4'd0;
        repeat (2) @(negedge clk);
`ifdef MM_ACC_DEBUG_EN
        n_checks++;
        if (acc_rdata !== 32'hBFFF8000) begin
            n_fail++; $display("FAIL wrap_acc0: got %h expected bfff8000", acc_rdata);
        end
        acc_sel = 4'd9;
        repeat (2) @(negedge clk);
        n_checks++;
        if (acc_rdata !== 32'd0) begin
            n_fail++; $display("FAIL acc_sel_oob: got %h expected 0", acc_rdata);
        end
`else
        n_checks++;
        if (acc_rdata !== 32'd0) begin
            n_fail++; $display("FAIL acc_rdata_off: got %h expected 0", acc_rdata);
        end
`endif
    endtask

    task automatic test_random();
        int a [9], b [9], bs [9];
        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < 9; k++) begin
                a[k]  = int'($signed(16'($urandom_range(0, 65535))));
                b[k]  = int'($signed(16'($urandom_range(0, 65535))));
                bs[k] = int'($signed(16'($urandom_range(0, 65535))));
            end
            load_all(a, b, bs, int'($signed(16'($urandom_range(0, 65535)))));
            test_run("random", -1);
        end
    endtask

    task automatic test_back_to_back();
        // Start again right after the previous done, without new writes.
        test_run("b2b_first", -1);
        test_run("b2b_second", -1);
    endtask

    initial begin
        test_reset();
        test_identity();
        test_bias_sign();
        test_threshold();
        test_busy_block();
        test_reset_mid_run();
        test_wrap();
        test_random();
        test_back_to_back();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_leftover: got %0d expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
